uart_tx_arbiter: RTL and testbench

Shares one UART transmit line among NUM_REQ requesters. It arbitrates round-robin, latches the winner's byte and serialises it as an 8N1-style frame. Bit timing comes from the oversampling tick produced by the team's baud_generator (bclk, one clk-wide pulse at BAUD_RATE × SAMPLING). It sits between the local message sources and the pad-level tx output.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 20 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int SAMPLING_DEFAULT = 16;

  // Counter/index width for a range of n values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: requests, bytes, grants and line status.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int IDW = width_of(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] data;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx;
  logic                         busy;
  logic [IDW-1:0]               active_id;

  modport master (output req, data, input grant, tx, busy, active_id);
  modport slave  (input req, data, output grant, tx, busy, active_id);

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after the pointer, cyclically.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = width_of(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  int cand_s;

  // Walk from the farthest candidate inward so the nearest one after ptr_i wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    cand_s   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s   = (int'(ptr_i) + k) % NUM_REQ;
      onehot_o = req_i[cand_s[IDW-1:0]] ? (NUM_REQ'(1) << cand_s) : onehot_o;
      idx_o    = req_i[cand_s[IDW-1:0]] ? IDW'(cand_s) : idx_o;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of one 8N1-style UART transmitter; bit timing
// comes from the bclk oversampling tick.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int SAMPLING  = SAMPLING_DEFAULT,
  parameter int STOP_BITS = 1
) (
  input logic              clk,
  input logic              reset,
  input logic              bclk,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDW = width_of(NUM_REQ);
  localparam int TW  = width_of(SAMPLING);
  localparam int BW  = width_of(DATA_BITS + 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic [NUM_REQ-1:0]   win_onehot_s;
  logic [IDW-1:0]       win_idx_s;
  logic                 win_valid_s;
  logic [DATA_BITS-1:0] win_data_s;
  logic                 bit_end_s;
  logic                 last_data_s;
  logic                 last_stop_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s),
    .valid_o  (win_valid_s)
  );

  // A bit ends on the cycle its SAMPLING-th tick is seen; the stop phase reuses bit_q.
  assign bit_end_s   = bclk && (tick_q == TW'(SAMPLING - 1));
  assign last_data_s = (bit_q == BW'(DATA_BITS - 1));
  assign last_stop_s = (bit_q == BW'(STOP_BITS - 1));

  // AND-OR select of the winner's byte.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = win_data_s | (bus.data[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{win_onehot_s[i]}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid_s) state_d = START; else state_d = IDLE;
      START:   if (bit_end_s) state_d = DATA; else state_d = START;
      DATA:    if (bit_end_s && last_data_s) state_d = STOP; else state_d = DATA;
      STOP:    if (bit_end_s && last_stop_s) state_d = IDLE; else state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the counters, shift register and registered outputs.
  always_comb begin
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    grant_d = '0;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (bclk) begin
      tick_d = bit_end_s ? '0 : tick_q + TW'(1);
    end else begin
      tick_d = tick_q;
    end
    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (win_valid_s) begin
          grant_d = win_onehot_s;
          id_d    = win_idx_s;
          ptr_d   = win_idx_s;
          shift_d = win_data_s;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end else begin
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          bit_d = '0;
          tx_d  = shift_q[0];
        end else begin
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s && last_data_s) begin
          bit_d = '0;
          tx_d  = 1'b1;
        end else if (bit_end_s) begin
          bit_d   = bit_q + BW'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end else begin
          bit_d = bit_q;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end_s && last_stop_s) begin
          bit_d  = '0;
          busy_d = 1'b0;
        end else if (bit_end_s) begin
          bit_d  = bit_q + BW'(1);
        end else begin
          bit_d  = bit_q;
        end
      end
      default: begin
        tick_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; the pointer resets so requester 0 is first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: SAMPLING=4, bclk every 3 clk, one DUT
// with one stop bit and one with two.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DB   = 8;
  localparam int SAMP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic bclk  = 1'b0;
  int   bdiv  = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = NREQ - 1;
  bit   sel = 1'b0;

  logic [NREQ-1:0] mon_grant;
  logic            mon_tx;
  logic            mon_busy;
  logic [1:0]      mon_id;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_BITS(DB)) bus1 ();
  uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_BITS(DB)) bus2 ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_BITS(DB), .SAMPLING(SAMP), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .bclk(bclk), .bus(bus1)
  );
  uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_BITS(DB), .SAMPLING(SAMP), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .bclk(bclk), .bus(bus2)
  );

  assign mon_grant = sel ? bus2.grant : bus1.grant;
  assign mon_tx    = sel ? bus2.tx : bus1.tx;
  assign mon_busy  = sel ? bus2.busy : bus1.busy;
  assign mon_id    = sel ? bus2.active_id : bus1.active_id;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bdiv == 2) begin
      bdiv <= 0;
      bclk <= 1'b1;
    end else begin
      bdiv <= bdiv + 1;
      bclk <= 1'b0;
    end
  end

  // Reference winner: first set request strictly after pointer p, cyclically.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Expected line value per bit: start 0, data LSB first, then sb stop ones.
  function automatic logic [11:0] exp_frame(input logic [7:0] d, input int sb);
    logic [11:0] f;
    f = '0;
    for (int i = 0; i < DB; i++) f[1 + i] = d[i];
    for (int i = 0; i < sb; i++) f[1 + DB + i] = 1'b1;
    return f;
  endfunction

  task automatic set_req(input logic [NREQ-1:0] r);
    if (sel) bus2.req = r;
    else     bus1.req = r;
  endtask

  // Observes one frame, segmenting the line by counted bclk ticks; drop: 0 hold, 1 winner, 2 all.
  task automatic run_frame(input int stop_bits, input int drop,
                           output bit tmo, output int lat, output logic [NREQ-1:0] g,
                           output logic [1:0] id, output logic [11:0] bits, output bit steady,
                           output logic end_busy, output logic end_tx);
    int n, b, tk, nb;
    bit newbit;
    logic cur;
    tmo = 1'b0; lat = 0; g = '0; id = '0; bits = '0; steady = 1'b1;
    end_busy = 1'bx; end_tx = 1'bx; nb = 1 + DB + stop_bits;
    n = 0;
    while (mon_grant == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mon_grant == '0) begin
      tmo = 1'b1;
      return;
    end
    lat = n; g = mon_grant; id = mon_id;
    if (drop == 1) set_req((sel ? bus2.req : bus1.req) & ~mon_grant);
    else if (drop == 2) set_req('0);
    b = 0; tk = 0; newbit = 1'b1; cur = 1'b0;
    for (int c = 0; c < 400 && b < nb; c++) begin
      if (newbit) begin
        bits[b] = mon_tx;
        cur = mon_tx;
        newbit = 1'b0;
      end else if (mon_tx !== cur) begin
        steady = 1'b0;
      end
      if (mon_busy !== 1'b1 || (c > 0 && mon_grant !== '0)) steady = 1'b0;
      if (bclk) begin
        tk++;
        if (tk == SAMP) begin
          tk = 0;
          b++;
          newbit = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (b < nb) tmo = 1'b1;
    end_busy = mon_busy;
    end_tx = mon_tx;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus1.req = '0;
    bus2.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = NREQ - 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus1.tx, bus1.busy, bus1.grant, bus1.active_id} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_dut1 got %b want %b", {bus1.tx, bus1.busy, bus1.grant, bus1.active_id}, 8'b1000_0000);
    end
    checks++;
    if ({bus2.tx, bus2.busy, bus2.grant} !== 6'b10_0000) begin
      errors++;
      $display("FAIL reset_dut2 got %b want %b", {bus2.tx, bus2.busy, bus2.grant}, 6'b10_0000);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus1.tx, bus1.busy, bus1.grant} !== 6'b10_0000) begin
      errors++;
      $display("FAIL idle_no_req got %b want %b", {bus1.tx, bus1.busy, bus1.grant}, 6'b10_0000);
    end
  endtask

  task automatic test_single_frame();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    bus1.data = {8'h3C, 8'h77, 8'hA5, 8'h11};
    bus1.req = 4'b0010;
    run_frame(1, 1, tmo, lat, g, id, bits, steady, eb, et);
    checks++;
    if (tmo || lat != 1) begin errors++; $display("FAIL single_latency got %0d (timeout %0d) want 1", lat, tmo); end
    checks++;
    if ({g, id} !== {4'b0010, 2'd1}) begin errors++; $display("FAIL single_grant_id got %b/%0d want 0010/1", g, id); end
    checks++;
    if (bits !== exp_frame(8'hA5, 1)) begin errors++; $display("FAIL single_bits got %b want %b", bits, exp_frame(8'hA5, 1)); end
    checks++;
    if (!steady || eb !== 1'b0 || et !== 1'b1) begin
      errors++; $display("FAIL single_shape got steady=%0d busy=%b tx=%b want 1/0/1", steady, eb, et);
    end
    model_ptr = 1;
  endtask

  task automatic test_round_robin();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] d;
    apply_reset();
    d = $urandom;
    bus1.data = d;
    bus1.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_frame(1, 0, tmo, lat, g, id, bits, steady, eb, et);
      if (i == 4) bus1.req = '0;
      checks++;
      if (tmo || g !== (4'(1) << order[i]) || lat != 1) begin
        errors++; $display("FAIL rr_grant[%0d] got %b lat %0d want %b lat 1", i, g, lat, 4'(1) << order[i]);
      end
      checks++;
      if (bits !== exp_frame(d[order[i]*8 +: 8], 1) || !steady || eb !== 1'b0) begin
        errors++; $display("FAIL rr_frame[%0d] got %b steady=%0d busy=%b want %b", i, bits, steady, eb, exp_frame(d[order[i]*8 +: 8], 1));
      end
    end
    model_ptr = 0;
  endtask

  task automatic test_pointer_wrap();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    int expw [3] = '{3, 0, 3};
    bus1.data = {8'hF0, 8'h00, 8'h00, 8'h0F};
    bus1.req = 4'b1000;
    run_frame(1, 2, tmo, lat, g, id, bits, steady, eb, et);
    bus1.req = 4'b1001;
    for (int i = 1; i < 3; i++) begin
      run_frame(1, 1, tmo, lat, g, id, bits, steady, eb, et);
      checks++;
      if (tmo || g !== (4'(1) << expw[i]) || id !== 2'(expw[i])) begin
        errors++; $display("FAIL wrap_grant[%0d] got %b id %0d want %b", i, g, id, 4'(1) << expw[i]);
      end
      checks++;
      if (bits !== exp_frame(i == 1 ? 8'h0F : 8'hF0, 1)) begin
        errors++; $display("FAIL wrap_bits[%0d] got %b want %b", i, bits, exp_frame(i == 1 ? 8'h0F : 8'hF0, 1));
      end
    end
    model_ptr = 3;
  endtask

  task automatic test_ignored_midframe();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    logic [NREQ-1:0] seen;
    bus1.data = {8'h00, 8'h5A, 8'h00, 8'hC3};
    bus1.req = 4'b0001;
    fork
      run_frame(1, 1, tmo, lat, g, id, bits, steady, eb, et);
      begin
        repeat (20) @(negedge clk);
        bus1.req[2] = 1'b1;
        repeat (5) @(negedge clk);
        bus1.req[2] = 1'b0;
      end
    join
    checks++;
    if (tmo || g !== 4'b0001) begin errors++; $display("FAIL ignored_grant got %b want 0001", g); end
    checks++;
    if (bits !== exp_frame(8'hC3, 1) || !steady) begin
      errors++; $display("FAIL ignored_frame got %b steady=%0d want %b", bits, steady, exp_frame(8'hC3, 1));
    end
    seen = '0;
    repeat (10) begin
      seen = seen | bus1.grant;
      @(negedge clk);
    end
    checks++;
    if (seen !== 4'b0000) begin errors++; $display("FAIL ignored_late_grant got %b want 0000", seen); end
    model_ptr = 0;
  endtask

  task automatic test_reset_midframe();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    int n;
    bus1.data = {8'h81, 8'h00, 8'hFF, 8'h00};
    bus1.req = 4'b0010;
    n = 0;
    while (bus1.grant == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus1.grant !== 4'b0010) begin errors++; $display("FAIL rstmid_grant got %b want 0010", bus1.grant); end
    bus1.req = '0;
    repeat (52) @(negedge clk);
    checks++;
    if (bus1.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", bus1.busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus1.tx, bus1.busy, bus1.grant, bus1.active_id} !== 8'b1000_0000) begin
      errors++; $display("FAIL rstmid_outputs got %b want %b", {bus1.tx, bus1.busy, bus1.grant, bus1.active_id}, 8'b1000_0000);
    end
    @(negedge clk);
    reset = 1'b0;
    model_ptr = NREQ - 1;
    @(negedge clk);
    checks++;
    if ({bus1.tx, bus1.busy} !== 2'b10) begin errors++; $display("FAIL rstmid_after got %b want 10", {bus1.tx, bus1.busy}); end
    bus1.req = 4'b1001;
    run_frame(1, 2, tmo, lat, g, id, bits, steady, eb, et);
    checks++;
    if (tmo || g !== 4'b0001 || bits !== exp_frame(8'h00, 1)) begin
      errors++; $display("FAIL rstmid_restart got %b bits %b want 0001 bits %b", g, bits, exp_frame(8'h00, 1));
    end
    model_ptr = 0;
  endtask

  task automatic test_stop_bits2();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    sel = 1'b1;
    bus2.data = {8'hEE, 8'hDD, 8'hCC, 8'h00};
    bus2.req = 4'b0001;
    run_frame(2, 2, tmo, lat, g, id, bits, steady, eb, et);
    checks++;
    if (tmo || g !== 4'b0001) begin errors++; $display("FAIL stop2_grant got %b want 0001", g); end
    checks++;
    if (bits !== exp_frame(8'h00, 2) || !steady || eb !== 1'b0 || et !== 1'b1) begin
      errors++; $display("FAIL stop2_frame got %b steady=%0d busy=%b want %b", bits, steady, eb, exp_frame(8'h00, 2));
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    bit tmo, steady; int lat; logic [NREQ-1:0] g; logic [1:0] id; logic [11:0] bits; logic eb, et;
    logic [NREQ-1:0] mask;
    logic [31:0] d;
    int w;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      mask = 4'($urandom_range(1, 15));
      d = $urandom;
      w = pick(mask, model_ptr);
      bus1.data = d;
      bus1.req = mask;
      run_frame(1, 2, tmo, lat, g, id, bits, steady, eb, et);
      checks++;
      if (tmo || lat != 1 || g !== (4'(1) << w) || id !== 2'(w)) begin
        errors++; $display("FAIL rand_grant[%0d] req %b got %b id %0d lat %0d want %b id %0d", i, mask, g, id, lat, 4'(1) << w, w);
      end
      checks++;
      if (bits !== exp_frame(d[w*8 +: 8], 1) || !steady || eb !== 1'b0 || et !== 1'b1) begin
        errors++; $display("FAIL rand_frame[%0d] got %b steady=%0d want %b", i, bits, steady, exp_frame(d[w*8 +: 8], 1));
      end
      model_ptr = w;
    end
  endtask

  initial begin
    bus1.req = '0;
    bus1.data = '0;
    bus2.req = '0;
    bus2.data = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_pointer_wrap();
    test_ignored_midframe();
    test_reset_midframe();
    test_stop_bits2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule
